fetch_stage: RTL

//  Instruction-fetch stage directly downstream of the next-PC select mux.

---
 rtl/fetch_stage.sv | 135 +++++++++++++
 1 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: fetch PC register, PC+4 generation, single-outstanding
// req/gnt/rvalid instruction-memory port and the IF/DE pipeline register.
module fetch_stage #(
  parameter logic [31:0] RESET_VEC = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_next,
  input  logic        redirect,
  input  logic        stall_d,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc_f,
  output logic [31:0] pc_seq,
  output logic [31:0] pc_d,
  output logic [31:0] instr_d,
  output logic        valid_d
);

  // StHold means the skid buffer holds a word that decode has not yet taken.
  typedef enum logic [1:0] {StIssue, StWait, StHold, StDrop} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_f_q, pc_f_d;
  logic [31:0] pc_d_q, pc_d_d;
  logic [31:0] instr_d_q, instr_d_d;
  logic        valid_d_q, valid_d_d;
  logic [31:0] skid_q, skid_d;

  logic        advance;
  logic [31:0] adv_word;
  logic [31:0] pc_next_aligned;

  assign pc_next_aligned = pc_next & 32'hFFFF_FFFC;

  // Request is masked while reset is asserted even though the state already reads StIssue.
  assign imem_req  = rst && (state_q == StIssue);
  assign imem_addr = pc_f_q;
  assign pc_f      = pc_f_q;
  assign pc_seq    = pc_f_q + 32'd4;
  assign pc_d      = pc_d_q;
  assign instr_d   = instr_d_q;
  assign valid_d   = valid_d_q;

  // Next-state for the fetch FSM, skid buffer, fetch PC and IF/DE register.
  always_comb begin
    state_d   = state_q;
    pc_f_d    = pc_f_q;
    pc_d_d    = pc_d_q;
    instr_d_d = instr_d_q;
    valid_d_d = valid_d_q;
    skid_d    = skid_q;
    advance   = 1'b0;
    adv_word  = imem_rdata;

    unique case (state_q)
      StIssue: begin
        if (redirect) begin
          state_d = imem_gnt ? StDrop : StIssue;
        end else if (imem_gnt) begin
          state_d = StWait;
        end
      end
      StWait: begin
        if (redirect) begin
          // A word arriving with the redirect is simply dropped.
          state_d = imem_rvalid ? StIssue : StDrop;
        end else if (imem_rvalid) begin
          if (stall_d) begin
            skid_d  = imem_rdata;
            state_d = StHold;
          end else begin
            advance = 1'b1;
            state_d = StIssue;
          end
        end
      end
      StHold: begin
        if (redirect) begin
          state_d = StIssue;
        end else if (!stall_d) begin
          advance  = 1'b1;
          adv_word = skid_q;
          state_d  = StIssue;
        end
      end
      StDrop: begin
        if (imem_rvalid) begin
          state_d = StIssue;
        end
      end
      default: state_d = StIssue;
    endcase

    if (redirect) begin
      pc_f_d    = pc_next_aligned;
      instr_d_d = NOP_INSTR;
      valid_d_d = 1'b0;
      skid_d    = '0;
    end else if (advance) begin
      pc_d_d    = pc_f_q;
      instr_d_d = adv_word;
      valid_d_d = 1'b1;
      pc_f_d    = pc_next_aligned;
      skid_d    = '0;
    end else if (!stall_d) begin
      // Decode consumed the previous instruction and nothing new arrived: bubble.
      valid_d_d = 1'b0;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIssue;
      pc_f_q    <= RESET_VEC;
      pc_d_q    <= '0;
      instr_d_q <= NOP_INSTR;
      valid_d_q <= 1'b0;
      skid_q    <= '0;
    end else begin
      state_q   <= state_d;
      pc_f_q    <= pc_f_d;
      pc_d_q    <= pc_d_d;
      instr_d_q <= instr_d_d;
      valid_d_q <= valid_d_d;
      skid_q    <= skid_d;
    end
  end

endmodule
